// File: rtl/noc_pkg.sv
// Shared NoC flit definitions for the memory-port arbiter slice.
package noc_pkg;

  localparam int NOC_BYTES        = 32;
  localparam int NOC_BP_W         = 6;
  localparam int NOC_CMD_READ_BIT = 0;

  typedef struct packed {
    logic [31:0][7:0] dat;
    logic [5:0]       bp;
    logic             bo;
  } noc_flit_t;

  function automatic logic noc_is_read(input logic [NOC_BYTES-1:0][7:0] dat);
    return dat[0][NOC_CMD_READ_BIT];
  endfunction

endpackage

// File: rtl/noc_id_fifo.sv
// In-order FIFO of requester IDs for reads awaiting their response flit.
// A push while full is accepted only together with a pop in the same cycle.
module noc_id_fifo
  import noc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 1
) (
  input  logic                   fclk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [PW:0]   count_r;
  logic          push_ok_s;
  logic          pop_ok_s;

  assign empty     = (count_r == (PW+1)'(0));
  assign full      = (count_r == (PW+1)'(DEPTH));
  assign pop_ok_s  = pop & ~empty;
  assign push_ok_s = push & (~full | pop_ok_s);
  assign dout      = mem_r[rd_ptr_r];
  assign count     = count_r;

  // ID storage, written at the tail on an accepted push
  always_ff @(posedge fclk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH
  always_ff @(posedge fclk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + (PW+1)'(1);
        2'b01:   count_r <= count_r - (PW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/noc_mem_arbiter.sv
// Round-robin arbiter sharing one memory_interface NoC port among N_REQ
// requesters; read responses are steered back in issue order.
module noc_mem_arbiter
  import noc_pkg::*;
#(
  parameter int N_REQ       = 2,
  parameter int OUTSTANDING = 4
) (
  input  logic                                      fclk,
  input  logic                                      rst,
  input  logic [N_REQ-1:0][NOC_BYTES-1:0][7:0]      req_dat,
  input  logic [N_REQ-1:0][NOC_BP_W-1:0]            req_bp,
  input  logic [N_REQ-1:0]                          req_bo,
  output logic [N_REQ-1:0]                          req_ack,
  output logic [N_REQ-1:0][NOC_BYTES-1:0][7:0]      rsp_dat,
  output logic [N_REQ-1:0][NOC_BP_W-1:0]            rsp_bp,
  output logic [N_REQ-1:0]                          rsp_bo,
  output logic [NOC_BYTES-1:0][7:0]                 mem_dat,
  output logic [NOC_BP_W-1:0]                       mem_bp,
  output logic                                      mem_bo,
  input  logic [NOC_BYTES-1:0][7:0]                 mem_rsp_dat,
  input  logic [NOC_BP_W-1:0]                       mem_rsp_bp,
  input  logic                                      mem_rsp_bo,
  output logic [$clog2(OUTSTANDING+1)-1:0]          outstanding,
  output logic                                      rsp_err
);

  localparam int W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]                     elig_s;
  logic [N_REQ-1:0]                     grant_s;
  logic                                 found_s;
  logic [W-1:0]                         win_s;
  int                                   idx_s;
  logic [W-1:0]                         last_r;
  logic                                 fifo_full_s;
  logic                                 fifo_empty_s;
  logic                                 fifo_pop_s;
  logic                                 fifo_push_s;
  logic                                 orphan_s;
  logic [W-1:0]                         head_s;
  noc_flit_t                            mem_r;
  logic [N_REQ-1:0][NOC_BYTES-1:0][7:0] rsp_dat_r;
  logic [N_REQ-1:0][NOC_BP_W-1:0]       rsp_bp_r;
  logic [N_REQ-1:0]                     rsp_bo_r;
  logic                                 rsp_err_r;

  assign fifo_pop_s  = mem_rsp_bo & ~fifo_empty_s;
  assign orphan_s    = mem_rsp_bo & fifo_empty_s;
  assign fifo_push_s = found_s & rst & noc_is_read(req_dat[win_s]);

  // Eligibility: writes always, reads only if the ID FIFO has room now or a pop frees it
  always_comb begin
    elig_s = '0;
    for (int i = 0; i < N_REQ; i++) begin
      elig_s[i] = req_bo[i] & (~noc_is_read(req_dat[i]) | ~fifo_full_s | fifo_pop_s);
    end
  end

  // Round-robin search starting one past the last winner
  always_comb begin
    found_s = 1'b0;
    win_s   = '0;
    idx_s   = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx_s = (int'(last_r) + k) % N_REQ;
      if (!found_s && elig_s[idx_s]) begin
        found_s = 1'b1;
        win_s   = idx_s[W-1:0];
      end else begin
        found_s = found_s;
      end
    end
  end

  // One-hot grant for the selected requester
  always_comb begin
    grant_s = '0;
    if (found_s) begin
      grant_s[win_s] = 1'b1;
    end else begin
      grant_s = '0;
    end
  end

  assign req_ack = rst ? grant_s : '0;

  noc_id_fifo #(
    .DEPTH (OUTSTANDING),
    .W     (W)
  ) u_id_fifo (
    .fclk  (fclk),
    .rst   (rst),
    .push  (fifo_push_s),
    .pop   (fifo_pop_s),
    .din   (win_s),
    .dout  (head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (outstanding)
  );

  // Forward the granted flit and remember the winner for the next search
  always_ff @(posedge fclk or negedge rst) begin
    if (!rst) begin
      mem_r  <= '0;
      last_r <= W'(N_REQ - 1);
    end else begin
      mem_r.bo <= found_s;
      if (found_s) begin
        mem_r.dat <= req_dat[win_s];
        mem_r.bp  <= req_bp[win_s];
        last_r    <= win_s;
      end
    end
  end

  // Steer a response to the FIFO head; an orphan response only raises the sticky error
  always_ff @(posedge fclk or negedge rst) begin
    if (!rst) begin
      rsp_dat_r <= '0;
      rsp_bp_r  <= '0;
      rsp_bo_r  <= '0;
      rsp_err_r <= 1'b0;
    end else begin
      rsp_bo_r <= '0;
      if (fifo_pop_s) begin
        rsp_bo_r[head_s]  <= 1'b1;
        rsp_dat_r[head_s] <= mem_rsp_dat;
        rsp_bp_r[head_s]  <= mem_rsp_bp;
      end
      if (orphan_s) begin
        rsp_err_r <= 1'b1;
      end
    end
  end

  assign mem_dat = mem_r.dat;
  assign mem_bp  = mem_r.bp;
  assign mem_bo  = mem_r.bo;
  assign rsp_dat = rsp_dat_r;
  assign rsp_bp  = rsp_bp_r;
  assign rsp_bo  = rsp_bo_r;
  assign rsp_err = rsp_err_r;

endmodule

// File: tb/tb_noc_mem_arbiter.sv
// Scoreboard bench for noc_mem_arbiter with two requesters and four outstanding reads.
module tb_noc_mem_arbiter;

  typedef struct packed {
    logic [31:0][7:0] dat;
    logic [5:0]       bp;
  } flit_t;

  typedef struct packed {
    logic [2:0]       id;
    logic [31:0][7:0] dat;
    logic [5:0]       bp;
  } rsp_t;

  logic                  fclk = 1'b0;
  logic                  rst;
  logic [1:0][31:0][7:0] req_dat;
  logic [1:0][5:0]       req_bp;
  logic [1:0]            req_bo;
  logic [1:0]            req_ack;
  logic [1:0][31:0][7:0] rsp_dat;
  logic [1:0][5:0]       rsp_bp;
  logic [1:0]            rsp_bo;
  logic [31:0][7:0]      mem_dat;
  logic [5:0]            mem_bp;
  logic                  mem_bo;
  logic [31:0][7:0]      mem_rsp_dat;
  logic [5:0]            mem_rsp_bp;
  logic                  mem_rsp_bo;
  logic [2:0]            outstanding;
  logic                  rsp_err;

  flit_t mem_q[$];
  rsp_t  rsp_q[$];
  int    id_q[$];
  int    errors = 0;
  int    checks = 0;

  noc_mem_arbiter #(.N_REQ(2), .OUTSTANDING(4)) dut (
    .fclk        (fclk),
    .rst         (rst),
    .req_dat     (req_dat),
    .req_bp      (req_bp),
    .req_bo      (req_bo),
    .req_ack     (req_ack),
    .rsp_dat     (rsp_dat),
    .rsp_bp      (rsp_bp),
    .rsp_bo      (rsp_bo),
    .mem_dat     (mem_dat),
    .mem_bp      (mem_bp),
    .mem_bo      (mem_bo),
    .mem_rsp_dat (mem_rsp_dat),
    .mem_rsp_bp  (mem_rsp_bp),
    .mem_rsp_bo  (mem_rsp_bo),
    .outstanding (outstanding),
    .rsp_err     (rsp_err)
  );

  always #5 fclk = ~fclk;

  function automatic flit_t mk_flit(input bit rd, input logic [5:0] bp);
    flit_t f;
    for (int b = 0; b < 32; b++) f.dat[b] = 8'($urandom);
    f.dat[0][0] = rd;
    f.bp = bp;
    return f;
  endfunction

  task automatic cyc();
    @(posedge fclk);
    #1;
  endtask

  task automatic mid();
    @(negedge fclk);
  endtask

  task automatic present(input int i, input flit_t f);
    req_dat[i] = f.dat;
    req_bp[i]  = f.bp;
    req_bo[i]  = 1'b1;
  endtask

  task automatic send_rsp(input logic [5:0] bp, input bit expect_route);
    rsp_t r;
    mem_rsp_bo  = 1'b1;
    mem_rsp_dat = mk_flit(1'b0, bp).dat;
    mem_rsp_bp  = bp;
    if (expect_route) begin
      r.id  = 3'(id_q.pop_front());
      r.dat = mem_rsp_dat;
      r.bp  = bp;
      rsp_q.push_back(r);
    end
  endtask

  task automatic do_reset();
    rst        = 1'b0;
    req_bo     = 2'b00;
    mem_rsp_bo = 1'b0;
    cyc();
    cyc();
    rst = 1'b1;
    mem_q.delete();
    rsp_q.delete();
    id_q.delete();
  endtask

  // Scoreboard monitor: every forwarded request and routed response must match the front of its queue
  initial begin
    flit_t me;
    rsp_t  re;
    forever begin
      @(negedge fclk);
      if (rst && mem_bo) begin
        checks++;
        if (mem_q.size() == 0) begin
          errors++;
          $display("FAIL mem_unexpected: got mem_bo=1 bp=%0d, required no forwarded flit", mem_bp);
        end else begin
          me = mem_q.pop_front();
          if (mem_dat !== me.dat || mem_bp !== me.bp) begin
            errors++;
            $display("FAIL mem_flit: got dat=%h bp=%0d, required dat=%h bp=%0d", mem_dat, mem_bp, me.dat, me.bp);
          end
        end
      end
      if (rst && rsp_bo != 2'b00) begin
        checks++;
        if ($countones(rsp_bo) > 1) begin
          errors++;
          $display("FAIL rsp_onehot: got rsp_bo=%b, required at most one bit", rsp_bo);
        end
      end
      for (int i = 0; i < 2; i++) begin
        if (rst && rsp_bo[i]) begin
          checks++;
          if (rsp_q.size() == 0) begin
            errors++;
            $display("FAIL rsp_unexpected: got rsp_bo[%0d]=1, required no response", i);
          end else begin
            re = rsp_q.pop_front();
            if (re.id !== 3'(i) || rsp_dat[i] !== re.dat || rsp_bp[i] !== re.bp) begin
              errors++;
              $display("FAIL rsp_route: got port %0d bp=%0d, required port %0d bp=%0d dat=%h",
                       i, rsp_bp[i], re.id, re.bp, re.dat);
            end
          end
        end
      end
    end
  end

  task automatic test_reset();
    flit_t f0;
    f0 = mk_flit(1'b0, 6'd32);
    rst = 1'b0;
    present(0, f0);
    present(1, mk_flit(1'b0, 6'd16));
    cyc();
    cyc();
    mid();
    checks++; if (req_ack !== 2'b00) begin errors++; $display("FAIL reset_ack: got %b, required 00", req_ack); end
    checks++; if (mem_bo !== 1'b0) begin errors++; $display("FAIL reset_mem_bo: got %b, required 0", mem_bo); end
    checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL reset_outstanding: got %0d, required 0", outstanding); end
    checks++; if (rsp_bo !== 2'b00 || rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp: got rsp_bo=%b rsp_err=%b, required 00/0", rsp_bo, rsp_err); end
    checks++; if (mem_dat !== '0 || mem_bp !== 6'd0) begin errors++; $display("FAIL reset_mem_data: got bp=%0d, required zero data", mem_bp); end
    cyc();
    rst = 1'b1;
    mid();
    checks++; if (req_ack !== 2'b01) begin errors++; $display("FAIL reset_first_ack: got %b, required 01", req_ack); end
    mem_q.push_back(f0);
    cyc();
    req_bo = 2'b00;
    cyc();
    cyc();
    mid();
    checks++; if (mem_q.size() != 0) begin errors++; $display("FAIL reset_fwd_missing: got %0d pending, required 0", mem_q.size()); end
    cyc();
  endtask

  task automatic test_round_robin();
    flit_t f[2];
    do_reset();
    f[0] = mk_flit(1'b0, 6'd4);
    f[1] = mk_flit(1'b0, 6'd12);
    present(0, f[0]);
    present(1, f[1]);
    for (int k = 0; k < 6; k++) begin
      mid();
      checks++;
      if (req_ack !== (2'b01 << (k % 2))) begin
        errors++;
        $display("FAIL rr_ack[%0d]: got %b, required %b", k, req_ack, 2'b01 << (k % 2));
      end
      mem_q.push_back(f[k % 2]);
      cyc();
      f[k % 2] = mk_flit(1'b0, 6'(k + 1));
      present(k % 2, f[k % 2]);
    end
    req_bo = 2'b00;
    cyc();
    cyc();
    mid();
    checks++; if (mem_q.size() != 0) begin errors++; $display("FAIL rr_fwd_missing: got %0d pending, required 0", mem_q.size()); end
    cyc();
  endtask

  task automatic test_fifo_full();
    flit_t f;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      f = mk_flit(1'b1, 6'd8);
      present(0, f);
      mid();
      checks++; if (req_ack !== 2'b01) begin errors++; $display("FAIL full_read_ack[%0d]: got %b, required 01", k, req_ack); end
      mem_q.push_back(f);
      id_q.push_back(0);
      cyc();
    end
    present(0, mk_flit(1'b1, 6'd8));
    mid();
    checks++; if (req_ack !== 2'b00) begin errors++; $display("FAIL full_stall: got %b, required 00", req_ack); end
    checks++; if (outstanding !== 3'd4) begin errors++; $display("FAIL full_outstanding: got %0d, required 4", outstanding); end
    cyc();
    f = mk_flit(1'b0, 6'd20);
    present(1, f);
    mid();
    checks++; if (req_ack !== 2'b10) begin errors++; $display("FAIL full_write_ack: got %b, required 10", req_ack); end
    mem_q.push_back(f);
    cyc();
    req_bo[1] = 1'b0;
    mid();
    checks++; if (req_ack !== 2'b00) begin errors++; $display("FAIL full_still_stall: got %b, required 00", req_ack); end
    cyc();
    req_bo = 2'b00;
  endtask

  task automatic test_push_pop();
    flit_t f;
    f = mk_flit(1'b1, 6'd24);
    present(1, f);
    send_rsp(6'd16, 1'b1);
    mid();
    checks++; if (req_ack !== 2'b10) begin errors++; $display("FAIL pp_ack: got %b, required 10", req_ack); end
    mem_q.push_back(f);
    id_q.push_back(1);
    cyc();
    req_bo     = 2'b00;
    mem_rsp_bo = 1'b0;
    mid();
    checks++; if (outstanding !== 3'd4) begin errors++; $display("FAIL pp_outstanding: got %0d, required 4", outstanding); end
    cyc();
    for (int k = 0; k < 4; k++) begin
      send_rsp(6'(k + 1), 1'b1);
      cyc();
    end
    mem_rsp_bo = 1'b0;
    cyc();
    mid();
    checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL pp_drained: got %0d, required 0", outstanding); end
    checks++; if (rsp_q.size() != 0 || mem_q.size() != 0) begin errors++; $display("FAIL pp_missing: got rsp=%0d mem=%0d pending, required 0", rsp_q.size(), mem_q.size()); end
    cyc();
  endtask

  task automatic test_in_order();
    flit_t f;
    int    order[3];
    logic [5:0] bps[3];
    order = '{1, 0, 1};
    bps   = '{6'd32, 6'd8, 6'd4};
    do_reset();
    for (int k = 0; k < 3; k++) begin
      req_bo = 2'b00;
      f = mk_flit(1'b1, 6'd2);
      present(order[k], f);
      mid();
      checks++; if (req_ack !== (2'b01 << order[k])) begin errors++; $display("FAIL order_ack[%0d]: got %b, required %b", k, req_ack, 2'b01 << order[k]); end
      mem_q.push_back(f);
      id_q.push_back(order[k]);
      cyc();
    end
    req_bo = 2'b00;
    for (int k = 0; k < 3; k++) begin
      send_rsp(bps[k], 1'b1);
      cyc();
    end
    mem_rsp_bo = 1'b0;
    cyc();
    mid();
    checks++; if (rsp_q.size() != 0) begin errors++; $display("FAIL order_missing: got %0d pending, required 0", rsp_q.size()); end
    checks++; if (outstanding !== 3'd0 || rsp_err !== 1'b0) begin errors++; $display("FAIL order_end: got outstanding=%0d rsp_err=%b, required 0/0", outstanding, rsp_err); end
    cyc();
  endtask

  task automatic test_orphan();
    flit_t f;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      req_bo = 2'b00;
      f = mk_flit(1'b1, 6'd6);
      present(k, f);
      mid();
      checks++; if (req_ack !== (2'b01 << k)) begin errors++; $display("FAIL orphan_ack[%0d]: got %b, required %b", k, req_ack, 2'b01 << k); end
      mem_q.push_back(f);
      cyc();
    end
    req_bo = 2'b00;
    cyc();
    mid();
    checks++; if (outstanding !== 3'd2) begin errors++; $display("FAIL orphan_pre: got %0d, required 2", outstanding); end
    cyc();
    rst = 1'b0;
    mid();
    checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL orphan_flush: got %0d, required 0", outstanding); end
    cyc();
    rst = 1'b1;
    mid();
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL orphan_err_pre: got %b, required 0", rsp_err); end
    cyc();
    send_rsp(6'd8, 1'b0);
    cyc();
    mem_rsp_bo = 1'b0;
    cyc();
    mid();
    checks++; if (rsp_err !== 1'b1) begin errors++; $display("FAIL orphan_err: got %b, required 1", rsp_err); end
    checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL orphan_outstanding: got %0d, required 0", outstanding); end
    cyc();
    cyc();
    mid();
    checks++; if (rsp_err !== 1'b1) begin errors++; $display("FAIL orphan_sticky: got %b, required 1", rsp_err); end
    cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b0;
    req_dat     = '0;
    req_bp      = '0;
    req_bo      = 2'b00;
    mem_rsp_dat = '0;
    mem_rsp_bp  = 6'd0;
    mem_rsp_bo  = 1'b0;
    cyc();
    test_reset();
    test_round_robin();
    test_fifo_full();
    test_push_pop();
    test_in_order();
    test_orphan();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
